// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the RV32I+Zicsr core.
// Steps each instruction through fetch/decode/execute/mem/writeback, runs the
// imem/dmem valid/ready handshakes and sequences trap entry and mret.
module core_sequencer #(
   parameter int unsigned RESET_SETTLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_valid,
   input  logic        imem_ready,
   input  logic        imem_err,
   output logic        dmem_valid,
   input  logic        dmem_ready,
   input  logic        dmem_err,
   input  logic        ins_illegal,
   input  logic        ecall,
   input  logic        ebreak,
   input  logic        trap_return,
   input  logic        dmem_read,
   input  logic        dmem_write,
   input  logic        rd_wen,
   input  logic        csr_op_nop,
   input  logic        dmem_misaligned,
   input  logic        jump_taken,
   input  logic        jump_misaligned,
   input  logic        irq_pending,
   output logic        ir_wen,
   output logic        rf_wen,
   output logic        csr_wen,
   output logic        pc_wen,
   output logic        trap_enter,
   output logic [31:0] trap_cause,
   output logic        mret,
   output logic        instret,
   output logic [2:0]  state
);

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned CAUSE_W = 32;

   localparam logic [CAUSE_W-1:0] CAUSE_INSN_MISALIGNED  = CAUSE_W'(0);
   localparam logic [CAUSE_W-1:0] CAUSE_INSN_FAULT       = CAUSE_W'(1);
   localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL          = CAUSE_W'(2);
   localparam logic [CAUSE_W-1:0] CAUSE_BREAKPOINT       = CAUSE_W'(3);
   localparam logic [CAUSE_W-1:0] CAUSE_LOAD_MISALIGNED  = CAUSE_W'(4);
   localparam logic [CAUSE_W-1:0] CAUSE_LOAD_FAULT       = CAUSE_W'(5);
   localparam logic [CAUSE_W-1:0] CAUSE_STORE_MISALIGNED = CAUSE_W'(6);
   localparam logic [CAUSE_W-1:0] CAUSE_STORE_FAULT      = CAUSE_W'(7);
   localparam logic [CAUSE_W-1:0] CAUSE_ECALL_M          = CAUSE_W'(11);
   localparam logic [CAUSE_W-1:0] CAUSE_IRQ_EXT          = 32'h8000_000B;

   typedef enum logic [2:0] {
      S_SETTLE    = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEM       = 3'd4,
      S_WRITEBACK = 3'd5,
      S_TRAP      = 3'd6,
      S_RETURN    = 3'd7
   } state_t;

   state_t               state_r;
   logic [CNT_W-1:0]     settle_cnt;
   logic [CAUSE_W-1:0]   cause_r;
   logic                 mem_is_load;
   logic                 mem_req;

   assign mem_req = dmem_read | dmem_write;

   // State sequencing; the trap cause is latched on every transition into TRAP.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_SETTLE;
         settle_cnt  <= CNT_W'(RESET_SETTLE - 1);
         cause_r     <= '0;
         mem_is_load <= 1'b0;
      end else begin
         unique case (state_r)
            S_SETTLE: begin
               if (settle_cnt == '0) state_r <= S_FETCH;
               else                  settle_cnt <= settle_cnt - CNT_W'(1);
            end
            S_FETCH: begin
               if (imem_ready) begin
                  if (imem_err) begin
                     state_r <= S_TRAP;
                     cause_r <= CAUSE_INSN_FAULT;
                  end else begin
                     state_r <= S_DECODE;
                  end
               end
            end
            S_DECODE: begin
               if (ins_illegal) begin
                  state_r <= S_TRAP;
                  cause_r <= CAUSE_ILLEGAL;
               end else if (ebreak) begin
                  state_r <= S_TRAP;
                  cause_r <= CAUSE_BREAKPOINT;
               end else if (ecall) begin
                  state_r <= S_TRAP;
                  cause_r <= CAUSE_ECALL_M;
               end else if (trap_return) begin
                  state_r <= S_RETURN;
               end else begin
                  state_r <= S_EXECUTE;
               end
            end
            S_EXECUTE: begin
               if (mem_req && dmem_misaligned) begin
                  state_r <= S_TRAP;
                  cause_r <= dmem_read ? CAUSE_LOAD_MISALIGNED : CAUSE_STORE_MISALIGNED;
               end else if (mem_req) begin
                  state_r     <= S_MEM;
                  mem_is_load <= dmem_read;
               end else if (jump_taken && jump_misaligned) begin
                  state_r <= S_TRAP;
                  cause_r <= CAUSE_INSN_MISALIGNED;
               end else begin
                  state_r <= S_WRITEBACK;
               end
            end
            S_MEM: begin
               if (dmem_ready) begin
                  if (dmem_err) begin
                     state_r <= S_TRAP;
                     cause_r <= mem_is_load ? CAUSE_LOAD_FAULT : CAUSE_STORE_FAULT;
                  end else begin
                     state_r <= S_WRITEBACK;
                  end
               end
            end
            S_WRITEBACK: begin
               // Interrupts are only taken at an instruction boundary.
               if (irq_pending) begin
                  state_r <= S_TRAP;
                  cause_r <= CAUSE_IRQ_EXT;
               end else begin
                  state_r <= S_FETCH;
               end
            end
            S_TRAP:   state_r <= S_FETCH;
            S_RETURN: state_r <= S_FETCH;
            default:  state_r <= S_SETTLE;
         endcase
      end
   end

   // Control strobes decoded from the registered state plus same-cycle handshakes.
   always_comb begin
      imem_valid = 1'b0;
      dmem_valid = 1'b0;
      ir_wen     = 1'b0;
      rf_wen     = 1'b0;
      csr_wen    = 1'b0;
      pc_wen     = 1'b0;
      trap_enter = 1'b0;
      trap_cause = '0;
      mret       = 1'b0;
      instret    = 1'b0;
      unique case (state_r)
         S_FETCH: begin
            imem_valid = 1'b1;
            ir_wen     = imem_ready & ~imem_err;
         end
         S_MEM: dmem_valid = 1'b1;
         S_WRITEBACK: begin
            rf_wen  = rd_wen;
            csr_wen = ~csr_op_nop;
            pc_wen  = 1'b1;
            instret = 1'b1;
         end
         S_TRAP: begin
            trap_enter = 1'b1;
            trap_cause = cause_r;
         end
         S_RETURN: begin
            mret    = 1'b1;
            instret = 1'b1;
         end
         default: ;
      endcase
   end

   assign state = state_r;

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: scoreboard bench for core_sequencer. Each instruction
// pushes its expected retire/trap/return events; they are popped and compared
// whenever the DUT raises pc_wen, trap_enter or mret.
module tb_core_sequencer;

   localparam int unsigned SETTLE = 3;
   localparam logic [31:0] IRQ_CAUSE = 32'h8000_000B;
   localparam logic [2:0] K_WB   = 3'b001;
   localparam logic [2:0] K_RET  = 3'b010;
   localparam logic [2:0] K_TRAP = 3'b100;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_valid, imem_ready, imem_err;
   logic        dmem_valid, dmem_ready, dmem_err;
   logic        ins_illegal, ecall, ebreak, trap_return;
   logic        dmem_read, dmem_write, rd_wen, csr_op_nop, dmem_misaligned;
   logic        jump_taken, jump_misaligned, irq_pending;
   logic        ir_wen, rf_wen, csr_wen, pc_wen, trap_enter, mret, instret;
   logic [31:0] trap_cause;
   logic [2:0]  state;

   always #5 clk = ~clk;

   core_sequencer #(.RESET_SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst),
      .imem_valid(imem_valid), .imem_ready(imem_ready), .imem_err(imem_err),
      .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_err(dmem_err),
      .ins_illegal(ins_illegal), .ecall(ecall), .ebreak(ebreak),
      .trap_return(trap_return), .dmem_read(dmem_read), .dmem_write(dmem_write),
      .rd_wen(rd_wen), .csr_op_nop(csr_op_nop), .dmem_misaligned(dmem_misaligned),
      .jump_taken(jump_taken), .jump_misaligned(jump_misaligned),
      .irq_pending(irq_pending),
      .ir_wen(ir_wen), .rf_wen(rf_wen), .csr_wen(csr_wen), .pc_wen(pc_wen),
      .trap_enter(trap_enter), .trap_cause(trap_cause), .mret(mret),
      .instret(instret), .state(state)
   );

   typedef struct packed {
      logic [2:0]  kind;
      logic [31:0] cause;
      logic        rf;
      logic        csr;
      logic        ret;
   } ev_t;

   ev_t sb_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc = 0, n_ir = 0, n_dv = 0, n_rf = 0, n_evt = 0;
   int cfg_iwait = 0, cfg_dwait = 0, iw_cnt = 0, dw_cnt = 0;
   logic cfg_ierr = 1'b0, cfg_derr = 1'b0, cfg_irq_dec = 1'b0;
   logic first_fetch_chk = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic [31:0] outs_vec();
      return 32'({imem_valid, dmem_valid, ir_wen, rf_wen, csr_wen, pc_wen,
                  trap_enter, mret, instret});
   endfunction

   function automatic ev_t ev_wb(input logic rf, input logic csr);
      return '{kind: K_WB, cause: 32'd0, rf: rf, csr: csr, ret: 1'b1};
   endfunction

   function automatic ev_t ev_trap(input logic [31:0] cause);
      return '{kind: K_TRAP, cause: cause, rf: 1'b0, csr: 1'b0, ret: 1'b0};
   endfunction

   function automatic ev_t ev_ret();
      return '{kind: K_RET, cause: 32'd0, rf: 1'b0, csr: 1'b0, ret: 1'b1};
   endfunction

   task automatic dec(input logic ill, input logic ec, input logic eb, input logic tr,
                      input logic rd, input logic wr, input logic rdw, input logic cnop,
                      input logic mis, input logic jt, input logic jm);
      ins_illegal = ill; ecall = ec; ebreak = eb; trap_return = tr;
      dmem_read = rd; dmem_write = wr; rd_wen = rdw; csr_op_nop = cnop;
      dmem_misaligned = mis; jump_taken = jt; jump_misaligned = jm;
   endtask

   // One clock: memory responders drive at negedge, outputs sampled 3ns later.
   task automatic step(input string tag);
      ev_t e;
      @(negedge clk);
      if (imem_valid) begin
         if (iw_cnt >= cfg_iwait) begin imem_ready = 1'b1; imem_err = cfg_ierr; end
         else begin imem_ready = 1'b0; imem_err = 1'b0; iw_cnt++; end
      end else begin
         imem_ready = 1'b0; imem_err = 1'b0; iw_cnt = 0;
      end
      if (dmem_valid) begin
         if (dw_cnt >= cfg_dwait) begin dmem_ready = 1'b1; dmem_err = cfg_derr; end
         else begin dmem_ready = 1'b0; dmem_err = 1'b0; dw_cnt++; end
      end else begin
         dmem_ready = 1'b0; dmem_err = 1'b0; dw_cnt = 0;
      end
      if (cfg_irq_dec && state == 3'd2) irq_pending = 1'b1;
      #3;
      cyc++;
      if (first_fetch_chk) begin
         check("first_fetch_imem_valid", 32'(imem_valid), 32'd1);
         first_fetch_chk = 1'b0;
      end
      if (ir_wen) n_ir++;
      if (dmem_valid) n_dv++;
      if (rf_wen) n_rf++;
      if (pc_wen || trap_enter || mret) begin
         n_evt++;
         if (sb_q.size() == 0) begin
            check({tag, "/unexpected_event"}, 32'({trap_enter, mret, pc_wen}), 32'd0);
         end else begin
            e = sb_q.pop_front();
            check({tag, "/kind"}, 32'({trap_enter, mret, pc_wen}), 32'(e.kind));
            if (e.kind == K_TRAP) check({tag, "/trap_cause"}, trap_cause, e.cause);
            check({tag, "/rf_wen"}, 32'(rf_wen), 32'(e.rf));
            check({tag, "/csr_wen"}, 32'(csr_wen), 32'(e.csr));
            check({tag, "/instret"}, 32'(instret), 32'(e.ret));
         end
      end
   endtask

   // Runs one instruction from its first FETCH cycle until n_ev events are seen.
   task automatic run_instr(input string tag, input int iwait, input logic ierr,
                            input int dwait, input logic derr, input logic irq_dec,
                            input int n_ev, input int exp_cyc, input int exp_ir,
                            input int exp_dv, input int exp_rf);
      int c0, e0, i0, d0, r0, budget;
      c0 = cyc; e0 = n_evt; i0 = n_ir; d0 = n_dv; r0 = n_rf; budget = 0;
      cfg_iwait = iwait; cfg_ierr = ierr; cfg_dwait = dwait; cfg_derr = derr;
      cfg_irq_dec = irq_dec;
      while (n_evt - e0 < n_ev) begin
         step(tag);
         budget++;
         if (budget > 60) begin
            check({tag, "/timeout_events"}, 32'(n_evt - e0), 32'(n_ev));
            break;
         end
      end
      check({tag, "/cycles"}, 32'(cyc - c0), 32'(exp_cyc));
      check({tag, "/ir_wen_count"}, 32'(n_ir - i0), 32'(exp_ir));
      check({tag, "/dmem_valid_cycles"}, 32'(n_dv - d0), 32'(exp_dv));
      check({tag, "/rf_wen_count"}, 32'(n_rf - r0), 32'(exp_rf));
      check({tag, "/sb_drained"}, 32'(sb_q.size()), 32'd0);
      cfg_irq_dec = 1'b0;
   endtask

   // Releases reset and walks the settle window; next step is the first FETCH.
   task automatic release_reset(input string tag);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < int'(SETTLE); i++) begin
         if (i > 0) @(negedge clk);
         #3;
         check({tag, "/settle_state"}, 32'(state), 32'd0);
         check({tag, "/settle_imem_valid"}, 32'(imem_valid), 32'd0);
      end
      first_fetch_chk = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      imem_ready = 1'b0; imem_err = 1'b0; dmem_ready = 1'b0; dmem_err = 1'b0;
      irq_pending = 1'b0;
      dec(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

      repeat (2) @(negedge clk);
      #3;
      check("reset/state", 32'(state), 32'd0);
      check("reset/outputs", outs_vec(), 32'd0);
      check("reset/trap_cause", trap_cause, 32'd0);
      release_reset("rel0");

      // addi with two imem wait states
      dec(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      sb_q.push_back(ev_wb(1'b1, 1'b0));
      run_instr("addi_wait2", 2, 0, 0, 0, 0, 1, 6, 1, 0, 1);

      // lw, zero-wait
      dec(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
      sb_q.push_back(ev_wb(1'b1, 1'b0));
      run_instr("lw_0wait", 0, 0, 0, 0, 0, 1, 5, 1, 1, 1);

      // lw with data bus error
      sb_q.push_back(ev_trap(32'd5));
      run_instr("lw_buserr", 0, 0, 0, 1, 0, 1, 5, 1, 1, 0);

      // sw with data bus error, one dmem wait state
      dec(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      sb_q.push_back(ev_trap(32'd7));
      run_instr("sw_buserr", 0, 0, 1, 1, 0, 1, 6, 1, 2, 0);

      // decode priority
      dec(1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      sb_q.push_back(ev_trap(32'd2));
      run_instr("illegal_ecall", 0, 0, 0, 0, 0, 1, 3, 1, 0, 0);
      dec(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      sb_q.push_back(ev_trap(32'd11));
      run_instr("ecall", 0, 0, 0, 0, 0, 1, 3, 1, 0, 0);
      dec(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
      sb_q.push_back(ev_trap(32'd3));
      run_instr("ebreak", 0, 0, 0, 0, 0, 1, 3, 1, 0, 0);
      dec(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
      sb_q.push_back(ev_ret());
      run_instr("mret", 0, 0, 0, 0, 0, 1, 3, 1, 0, 0);

      // execute-stage faults
      dec(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
      sb_q.push_back(ev_trap(32'd6));
      run_instr("sw_misaligned", 0, 0, 0, 0, 0, 1, 4, 1, 0, 0);
      dec(0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0);
      sb_q.push_back(ev_trap(32'd4));
      run_instr("lw_misaligned", 0, 0, 0, 0, 0, 1, 4, 1, 0, 0);
      dec(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1);
      sb_q.push_back(ev_trap(32'd0));
      run_instr("jal_misaligned", 0, 0, 0, 0, 0, 1, 4, 1, 0, 0);
      dec(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
      sb_q.push_back(ev_wb(1'b1, 1'b0));
      run_instr("jal_ok", 0, 0, 0, 0, 0, 1, 4, 1, 0, 1);
      dec(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      sb_q.push_back(ev_wb(1'b1, 1'b1));
      run_instr("csrrw", 0, 0, 0, 0, 0, 1, 4, 1, 0, 1);

      // instruction fetch bus error after one wait state
      dec(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      sb_q.push_back(ev_trap(32'd1));
      run_instr("fetch_buserr", 1, 1, 0, 0, 0, 1, 3, 0, 0, 0);

      // irq raised during DECODE: instruction retires, then trap
      sb_q.push_back(ev_wb(1'b1, 1'b0));
      sb_q.push_back(ev_trap(IRQ_CAUSE));
      run_instr("add_irq", 0, 0, 0, 0, 1, 2, 5, 1, 0, 1);

      // irq held across a fetch stall: still only taken after WRITEBACK
      sb_q.push_back(ev_wb(1'b1, 1'b0));
      sb_q.push_back(ev_trap(IRQ_CAUSE));
      run_instr("irq_held_stall", 2, 0, 0, 0, 0, 2, 7, 1, 0, 1);
      irq_pending = 1'b0;

      // reset asserted while a load waits in MEM
      dec(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
      sb_q.push_back(ev_wb(1'b1, 1'b0));
      cfg_dwait = 20; cfg_derr = 1'b0; cfg_iwait = 0; cfg_ierr = 1'b0;
      for (int i = 0; i < 10 && state != 3'd4; i++) step("rst_in_mem");
      check("rst_in_mem/reached_mem", 32'(state), 32'd4);
      @(negedge clk);
      rst = 1'b1;
      #3;
      check("rst_in_mem/dvalid_before_sample", 32'(dmem_valid), 32'd1);
      @(negedge clk);
      #3;
      check("rst_in_mem/dvalid_after", 32'(dmem_valid), 32'd0);
      check("rst_in_mem/state", 32'(state), 32'd0);
      check("rst_in_mem/outputs", outs_vec(), 32'd0);
      sb_q.delete();
      dmem_ready = 1'b0; imem_ready = 1'b0; iw_cnt = 0; dw_cnt = 0;
      release_reset("rel1");

      dec(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      sb_q.push_back(ev_wb(1'b1, 1'b0));
      run_instr("addi_after_rst", 0, 0, 0, 0, 0, 1, 4, 1, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule
